// File: rtl/m_stage_sched.sv
// SHA-256 message-schedule sequencer: loads W0..W15 into a circular window,
// drives the external M_Stage datapath once per word and streams W16..W63.
module m_stage_sched #(
   parameter int DATA_W = 32,
   parameter int LAT    = 2,
   parameter int S1_R1  = 17,
   parameter int S1_R2  = 19,
   parameter int S1_SH  = 10,
   parameter int S0_R1  = 7,
   parameter int S0_R2  = 18,
   parameter int S0_SH  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic              w_valid,
   output logic [DATA_W-1:0] w_data,
   input  logic              w_ready,
   output logic              block_done,
   output logic [DATA_W-1:0] m_in0,
   output logic [DATA_W-1:0] m_in1,
   output logic [DATA_W-1:0] m_in2,
   output logic [DATA_W-1:0] m_in3,
   output logic              m_run,
   input  logic [DATA_W-1:0] m_out0,
   output logic [31:0]       m_c0,
   output logic [31:0]       m_c1,
   output logic [31:0]       m_c2,
   output logic [31:0]       m_c3,
   output logic [31:0]       m_c4,
   output logic [31:0]       m_c5
);

   localparam int CW = (LAT < 2) ? 1 : $clog2(LAT + 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] ISSUE = 3'd2;
   localparam logic [2:0] WAIT  = 3'd3;
   localparam logic [2:0] EMIT  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [5:0]        t_q, t_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [CW-1:0]     cd_q, cd_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic [DATA_W-1:0] in0_q, in0_d;
   logic [DATA_W-1:0] in1_q, in1_d;
   logic [DATA_W-1:0] in2_q, in2_d;
   logic [DATA_W-1:0] in3_q, in3_d;
   logic              done_q, done_d;

   logic [DATA_W-1:0] win_q [16];
   logic              win_we;
   logic [3:0]        win_wa;
   logic [DATA_W-1:0] win_wd;

   logic              op_ld;
   logic [3:0]        op_t;

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      cnt_d   = cnt_q;
      cd_d    = cd_q;
      res_d   = res_q;
      done_d  = 1'b0;
      win_we  = 1'b0;
      win_wa  = cnt_q;
      win_wd  = load_data;
      op_ld   = 1'b0;
      op_t    = t_q[3:0];
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               cnt_d   = 4'd0;
            end
         end
         LOAD: begin
            if (load_valid) begin
               win_we = 1'b1;
               cnt_d  = cnt_q + 4'd1;
               if (cnt_q == 4'd15) begin
                  state_d = ISSUE;
                  t_d     = 6'd16;
                  op_ld   = 1'b1;
                  op_t    = 4'd0;
               end
            end
         end
         ISSUE: begin
            cd_d    = CW'(LAT);
            state_d = WAIT;
         end
         WAIT: begin
            cd_d = cd_q - CW'(1);
            if (cd_q == CW'(1)) begin
               res_d   = m_out0;
               win_we  = 1'b1;
               win_wa  = t_q[3:0];
               win_wd  = m_out0;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (w_ready) begin
               if (t_q == 6'd63) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  t_d     = t_q + 6'd1;
                  op_ld   = 1'b1;
                  op_t    = t_q[3:0] + 4'd1;
                  state_d = ISSUE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Operands are captured on entry to ISSUE so they are valid with m_run.
   always_comb begin
      in0_d = in0_q;
      in1_d = in1_q;
      in2_d = in2_q;
      in3_d = in3_q;
      if (op_ld) begin
         in0_d = win_q[op_t];
         in1_d = win_q[op_t + 4'd1];
         in2_d = win_q[op_t + 4'd9];
         in3_d = win_q[op_t + 4'd14];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         t_q     <= '0;
         cnt_q   <= '0;
         cd_q    <= '0;
         res_q   <= '0;
         in0_q   <= '0;
         in1_q   <= '0;
         in2_q   <= '0;
         in3_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         cnt_q   <= cnt_d;
         cd_q    <= cd_d;
         res_q   <= res_d;
         in0_q   <= in0_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
         in3_q   <= in3_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (win_we) win_q[win_wa] <= win_wd;
   end

   assign busy       = (state_q != IDLE);
   assign load_ready = (state_q == LOAD);
   assign w_valid    = (state_q == EMIT);
   assign m_run      = (state_q == ISSUE);
   assign w_data     = res_q;
   assign block_done = done_q;
   assign m_in0      = in0_q;
   assign m_in1      = in1_q;
   assign m_in2      = in2_q;
   assign m_in3      = in3_q;

   assign m_c0 = 32'(S1_R1);
   assign m_c1 = 32'(S1_R2);
   assign m_c2 = 32'(S1_SH);
   assign m_c3 = 32'(S0_R1);
   assign m_c4 = 32'(S0_R2);
   assign m_c5 = 32'(S0_SH);

endmodule

// File: tb/tb_m_stage_sched.sv
// Bench for m_stage_sched: models the M_Stage datapath with a LAT=2 pipe
// and compares the streamed schedule against a SHA-256 schedule model.
module tb_m_stage_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        load_valid = 1'b0;
   logic [31:0] load_data = '0;
   logic        w_ready = 1'b0;
   logic [31:0] m_out0;
   logic        busy, load_ready, w_valid, block_done, m_run;
   logic [31:0] w_data, m_in0, m_in1, m_in2, m_in3;
   logic [31:0] m_c0, m_c1, m_c2, m_c3, m_c4, m_c5;

   m_stage_sched dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy),
      .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .w_valid(w_valid), .w_data(w_data),
      .w_ready(w_ready), .block_done(block_done),
      .m_in0(m_in0), .m_in1(m_in1), .m_in2(m_in2), .m_in3(m_in3),
      .m_run(m_run), .m_out0(m_out0),
      .m_c0(m_c0), .m_c1(m_c1), .m_c2(m_c2),
      .m_c3(m_c3), .m_c4(m_c4), .m_c5(m_c5)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] s0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] s1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   // Datapath model: result of the operands seen with m_run, LAT=2 later.
   logic [31:0] pipe0, pipe1;
   always @(posedge clk) begin
      pipe0 <= m_run ? (m_in0 + s0(m_in1) + m_in2 + s1(m_in3)) : 32'hDEADBEEF;
      pipe1 <= pipe0;
   end
   assign m_out0 = pipe1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [31:0] blocks [3][16];
   logic [31:0] exp_w [3][64];
   logic [31:0] got [48];
   logic [31:0] res [3][48];

   typedef struct {
      string       name;
      int          pat;
      int          idx;
      logic [31:0] exp;
   } vec_t;
   vec_t vt [7];

   int nout, runs, dones, span, lr_cyc, stall_bad, busy_bad;

   function automatic int seq_err(input int pat);
      int e = 0;
      for (int i = 0; i < 48; i++)
         if (got[i] !== exp_w[pat][i+16]) e++;
      return e;
   endfunction

   task automatic run_block(input int pat, input int gap, input int stall,
                            input int extra, input int abort_at);
      int nload, first, dcyc, gapc, stc;
      bit pstall, abort_pend, fin;
      logic [31:0] pdata;
      nload = 0; first = -1; dcyc = -1; gapc = 0; stc = 0;
      pstall = 0; abort_pend = 0; fin = 0; pdata = '0;
      nout = 0; runs = 0; dones = 0; lr_cyc = -1;
      stall_bad = 0; busy_bad = 0; span = -1;
      for (int i = 0; i < 48; i++) got[i] = 'x;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (abort_pend) begin
            rst = 1'b0;
            #1;
            chk("abort_busy", busy, 0);
            chk("abort_w_valid", w_valid, 0);
            chk("abort_m_run", m_run, 0);
            chk("abort_w_data", w_data, 0);
            chk("abort_m_in0", m_in0, 0);
            @(negedge clk);
            chk("abort_busy_next", busy, 0);
            chk("abort_load_ready", load_ready, 0);
            chk("abort_m_in3", m_in3, 0);
            rst = 1'b1;
            fin = 1;
            break;
         end
         if (m_run) begin
            runs++;
            if (first < 0) first = cyc;
            if (abort_at >= 0 && nout == abort_at) abort_pend = 1;
         end
         if (block_done) begin
            dones++;
            dcyc = cyc;
            if (busy) busy_bad++;
         end
         if (load_ready && lr_cyc < 0) lr_cyc = cyc;
         if (pstall && !(w_valid && w_data === pdata)) stall_bad++;
         start = (cyc == 0) ||
                 (extra != 0 && ((load_ready && nload == 5) ||
                                 (w_valid && nout == 10)));
         if (cyc == 0 || nload >= 16) begin
            load_valid = (extra != 0) || (cyc == 0);
            load_data  = 32'hBADBAD00;
         end else begin
            load_valid = (gapc == 0);
            load_data  = blocks[pat][nload];
         end
         if (load_valid && load_ready) begin
            nload++;
            gapc = gap;
         end else if (gapc > 0) begin
            gapc--;
         end
         if (stall == 0) w_ready = 1'b1;
         else if (nout == 4 && stc < 5 && w_valid) begin
            w_ready = 1'b0;
            stc++;
         end else if (nout > 4) w_ready = 1'($urandom_range(0, 1));
         else w_ready = 1'b1;
         if (w_valid && w_ready) begin
            if (nout < 48) got[nout] = w_data;
            nout++;
         end
         pstall = w_valid && !w_ready;
         pdata  = w_data;
         if (dcyc >= 0 && cyc >= dcyc + 3) begin
            fin = 1;
            break;
         end
      end
      start = 1'b0;
      load_valid = 1'b0;
      w_ready = 1'b0;
      if (first >= 0 && dcyc >= 0) span = dcyc - first;
      if (!fin) chk("run_timeout", 0, 1);
   endtask

   initial begin
      for (int p = 0; p < 3; p++)
         for (int i = 0; i < 16; i++) blocks[p][i] = '0;
      blocks[0][0]  = 32'h61626380;
      blocks[0][15] = 32'h00000018;
      blocks[1][0]  = 32'h00000001;
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 16; i++) exp_w[p][i] = blocks[p][i];
         for (int i = 16; i < 64; i++)
            exp_w[p][i] = s1(exp_w[p][i-2]) + exp_w[p][i-7] +
                          s0(exp_w[p][i-15]) + exp_w[p][i-16];
      end
      vt[0] = '{"abc_w16",  0, 0,  32'h61626380};
      vt[1] = '{"abc_w17",  0, 1,  32'h000F0000};
      vt[2] = '{"one_w16",  1, 0,  32'h00000001};
      vt[3] = '{"one_w17",  1, 1,  32'h00000000};
      vt[4] = '{"one_w18",  1, 2,  32'h0000A000};
      vt[5] = '{"zero_w16", 2, 0,  32'h00000000};
      vt[6] = '{"zero_w63", 2, 47, 32'h00000000};

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_load_ready", load_ready, 0);
      chk("rst_w_valid", w_valid, 0);
      chk("rst_m_run", m_run, 0);
      chk("rst_block_done", block_done, 0);
      chk("rst_w_data", w_data, 0);
      chk("rst_m_in", {m_in0 | m_in1 | m_in2 | m_in3}, 0);
      chk("m_c", {m_c0[7:0], m_c1[7:0], m_c2[7:0],
                  m_c3[7:0], m_c4[7:0], m_c5[7:0]},
          {8'd17, 8'd19, 8'd10, 8'd7, 8'd18, 8'd3});
      rst = 1'b1;
      @(negedge clk);

      run_block(2, 0, 0, 0, -1);
      chk("zero_span", span, 192);
      chk("zero_runs", runs, 48);
      chk("zero_nout", nout, 48);
      chk("zero_done", dones, 1);
      chk("zero_lr_cyc", lr_cyc, 1);
      chk("zero_busy_at_done", busy_bad, 0);
      res[2] = got;

      run_block(0, 0, 0, 0, -1);
      chk("abc_seq", seq_err(0), 0);
      chk("abc_nout", nout, 48);
      chk("abc_done", dones, 1);
      res[0] = got;

      run_block(1, 0, 0, 0, -1);
      chk("one_seq", seq_err(1), 0);
      res[1] = got;

      for (int i = 0; i < 7; i++)
         chk(vt[i].name, res[vt[i].pat][vt[i].idx], vt[i].exp);

      run_block(0, 0, 1, 0, -1);
      chk("stall_seq", seq_err(0), 0);
      chk("stall_frozen", stall_bad, 0);
      chk("stall_runs", runs, 48);
      chk("stall_done", dones, 1);

      run_block(0, 3, 0, 1, -1);
      chk("extra_seq", seq_err(0), 0);
      chk("extra_runs", runs, 48);
      chk("extra_done", dones, 1);
      chk("extra_span", span, 192);

      run_block(0, 0, 0, 0, 14);
      chk("abort_partial", nout, 14);
      @(negedge clk);
      run_block(0, 0, 0, 0, -1);
      chk("post_abort_w16", got[0], 32'h61626380);
      chk("post_abort_seq", seq_err(0), 0);
      chk("post_abort_span", span, 192);
      chk("post_abort_done", dones, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/m_stage_sched.md
# m_stage_sched

Sequencer and configuration controller for the SHA-256 message-schedule datapath (`M_Stage`: two sigma units plus adder tree, single-word output). It loads one 16-word message block into a circular window and drives the datapath once per word to produce W[16..63]. It captures each result after a fixed latency, writes it back into the window, and streams it out under valid/ready. It sits between the block-load front end and the compression-round controller.

## Interface
- `DATA_W`, default 32: word width.
- `LAT`, default 2: cycles from `m_run` high to `m_out0` valid; must be ≥1.
- `S1_R1`, `S1_R2`, `S1_SH`, defaults 17, 19, 10: sigma1 rotate/rotate/shift amounts.
- `S0_R1`, `S0_R2`, `S0_SH`, defaults 7, 18, 3: sigma0 rotate/rotate/shift amounts.

Ports:
- `clk`  in  1: clock; one clock.
- `rst`  in  1: reset. Reset is asynchronous and active-low.
- `start`  in  1: one-cycle pulse; begins a block. Ignored unless IDLE.
- `busy`  out  1: high in every state except IDLE.
- `load_valid`  in  1, `load_data`  in  DATA_W, `load_ready`  out  1: W0..W15 input stream.
- `w_valid`  out  1, `w_data`  out  DATA_W, `w_ready`  in  1: W16..W63 output stream.
- `block_done`  out  1: one-cycle pulse after W63 is accepted.
- `m_in0`/`m_in1`/`m_in2`/`m_in3`  out  DATA_W each: W[t-16], W[t-15], W[t-7], W[t-2].
- `m_run`  out  1: datapath run strobe.
- `m_out0`  in  DATA_W: datapath result.
- `m_c0`..`m_c2`  out  32 each: S1_R1, S1_R2, S1_SH (sigma on `m_in3`), constant.
- `m_c3`..`m_c5`  out  32 each: S0_R1, S0_R2, S0_SH (sigma on `m_in1`), constant.

## Operation
- Storage: 16×DATA_W window `win`; 6-bit word index `t`; 4-bit load count; LAT countdown; DATA_W result register.
- Window mapping, all indices mod 16:
  - `m_in0` = win[t]
  - `m_in1` = win[t+1]
  - `m_in2` = win[t+9]
  - `m_in3` = win[t+14]
- IDLE: `load_ready`=0. On `start`, go to LOAD with load count=0.
- LOAD:
  - `load_ready`=1.
  - Each `load_valid`&`load_ready` writes win[count] and increments count.
  - The 16th accept goes to ISSUE with t=16.
  - Gaps in `load_valid` are allowed.
- ISSUE: register the four operands from the window, assert `m_run` for exactly one cycle, load countdown=LAT, go to WAIT.
- WAIT:
  - Operands held stable.
  - Decrement the countdown each cycle.
  - In the cycle the countdown equals 1, sample `m_out0` into the result register and write win[t mod 16].
  - Then go to EMIT.
- EMIT:
  - `w_valid`=1, `w_data`=result.
  - On `w_ready`: if t==63, go to IDLE with `block_done` pulse; else t+1 and go to ISSUE.
- Arithmetic: mod 2^DATA_W inside the datapath. The controller never modifies data.
- `m_c0`..`m_c5` are parameter-driven constants, valid from reset.

## Timing
- Reset values: `busy`, `load_ready`, `w_valid`, `m_run`, `block_done` = 0; `w_data`, `m_in0`..`m_in3` = 0; state IDLE; t=0; window contents undefined.
- `start` at cycle 0 gives `load_ready` high at cycle 1.
- With `w_ready` held high: LAT+2 cycles per word (ISSUE 1, WAIT LAT, EMIT 1).
  - 48·(LAT+2) cycles from the first ISSUE to the `block_done` pulse.
  - 192 cycles at LAT=2.
- `w_data` and `w_valid` stay stable while `w_ready`=0. No re-issue of `m_run`, no window write during the stall.
- `start` while `busy` is ignored. `load_valid` outside LOAD is ignored.
- `block_done` and `busy` fall in the same cycle. A `start` in the cycle after `block_done` is accepted.
- `rst` asserted in any state clears all state immediately. An in-flight result is discarded. The next block needs a fresh `start` and a full 16-word reload.

## Test plan
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018) → W16=0x61626380, W17=0x000F0000; exactly 48 output words, then one `block_done` pulse.
- W0=0x00000001, rest 0 → W16=0x00000001, W17=0x00000000, W18=0x0000A000.
- All-zero block, `w_ready`=1, LAT=2 → 48 zero words; `block_done` exactly 192 cycles after the first `m_run`; `m_run` high exactly 48 cycles total.
- "abc" block with `w_ready`=0 for 5 cycles at W20 and randomly toggled afterwards → `w_data` frozen during stalls; sequence identical to the unstalled run; no extra `m_run` pulses.
- `start` pulsed during LOAD and EMIT, `load_valid` with 3-cycle gaps → extra starts have no effect; loaded words land in order; outputs unchanged.
- `rst` low for 1 cycle during WAIT of W30 → all outputs at reset values next cycle; `busy`=0. A subsequent "abc" block reproduces W16=0x61626380 with correct timing.
